// File: rtl/adder_pkg.sv
// Shared definitions for the registered carry-lookahead adder.
// Contents: default operand width, CLA group width, default data type.
package adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned GROUP_W       = 4;

    typedef logic [DEFAULT_WIDTH-1:0] data_t;

endpackage : adder_pkg

// File: rtl/adder_cla4.sv
// Combinational 4-bit carry-lookahead group.
// Ports:
//   a, b  : 4-bit operand slices
//   cin   : carry into the group
//   sum   : 4-bit sum slice
//   cout  : carry out of the group
module adder_cla4
    import adder_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] sum,
    output logic               cout
);

    logic [GROUP_W-1:0] g;
    logic [GROUP_W-1:0] p;
    logic [GROUP_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded from cin directly, so no carry ripples inside the group.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[GROUP_W-1:0];
    assign cout = c[GROUP_W];

endmodule : adder_cla4

// File: rtl/adder.sv
// Registered unsigned modulo-2^WIDTH adder built from chained 4-bit CLA groups.
// Ports:
//   clk_i   : clock, rising edge
//   reset_i : synchronous active-low clear of res
//   a, b    : WIDTH-bit unsigned operands
//   res     : registered (a + b) mod 2^WIDTH, one cycle latency
module adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res
);

    localparam int unsigned NUM_GROUPS = WIDTH / GROUP_W;

    // Reject widths the group chain cannot tile exactly.
    if ((WIDTH % GROUP_W) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_width_check
        $fatal(1, "adder: WIDTH must be a multiple of 4 in 4..64");
    end

    logic [WIDTH-1:0]    sum_c;
    logic [NUM_GROUPS:0] carry;
    logic                unused_carry;

    assign carry[0] = 1'b0;

    // Group carry chain, LSB group first.
    for (genvar gi = 0; gi < NUM_GROUPS; gi++) begin : g_cla
        adder_cla4 u_cla4 (
            .a    (a[gi*GROUP_W +: GROUP_W]),
            .b    (b[gi*GROUP_W +: GROUP_W]),
            .cin  (carry[gi]),
            .sum  (sum_c[gi*GROUP_W +: GROUP_W]),
            .cout (carry[gi+1])
        );
    end

    // Carry out of the MSB is dropped so the sum wraps.
    assign unused_carry = carry[NUM_GROUPS];

    // Result register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            res <= '0;
        end else begin
            res <= sum_c;
        end
    end

endmodule : adder

// File: tb/tb_adder.sv
// Self-checking bench for adder at WIDTH 8, 16 and 32 sharing one clock/reset.
module tb_adder;

    logic        clk_i;
    logic        reset_i;
    logic [7:0]  a8,  b8,  res8;
    logic [15:0] a16, b16, res16;
    logic [31:0] a32, b32, res32;

    int n_checks;
    int n_fail;

    adder #(.WIDTH(8)) u_dut8 (
        .clk_i(clk_i), .reset_i(reset_i), .a(a8), .b(b8), .res(res8)
    );
    adder #(.WIDTH(16)) u_dut16 (
        .clk_i(clk_i), .reset_i(reset_i), .a(a16), .b(b16), .res(res16)
    );
    adder #(.WIDTH(32)) u_dut32 (
        .clk_i(clk_i), .reset_i(reset_i), .a(a32), .b(b32), .res(res32)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference: true integer sum reduced modulo 2^w.
    function automatic logic [31:0] ref_sum(input logic [31:0] x, input logic [31:0] y,
                                            input int unsigned w);
        logic [63:0] s;
        s = {32'd0, x} + {32'd0, y};
        return 32'(s % (64'd1 << w));
    endfunction

    // Drive one operand set away from the edge, then wait until just after the edge.
    task automatic step(input logic rst, input logic [7:0] x8, input logic [7:0] y8,
                        input logic [15:0] x16, input logic [15:0] y16,
                        input logic [31:0] x32, input logic [31:0] y32);
        @(negedge clk_i);
        reset_i = rst;
        a8  = x8;  b8  = y8;
        a16 = x16; b16 = y16;
        a32 = x32; b32 = y32;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 8'h55, 8'h22, 16'h5555, 16'h2222, 32'h5555_5555, 32'h2222_2222);
            n_checks += 3;
            if (res8 !== 8'h00) begin
                n_fail++; $display("FAIL reset8[%0d]: got %h expected 00", i, res8);
            end
            if (res16 !== 16'h0000) begin
                n_fail++; $display("FAIL reset16[%0d]: got %h expected 0000", i, res16);
            end
            if (res32 !== 32'h0) begin
                n_fail++; $display("FAIL reset32[%0d]: got %h expected 0", i, res32);
            end
        end
        step(1'b1, 8'h55, 8'h22, 16'h5555, 16'h2222, 32'h5555_5555, 32'h2222_2222);
        n_checks += 3;
        if (res8 !== 8'h77) begin
            n_fail++; $display("FAIL reset_release8: got %h expected 77", res8);
        end
        if (res16 !== 16'h7777) begin
            n_fail++; $display("FAIL reset_release16: got %h expected 7777", res16);
        end
        if (res32 !== 32'h7777_7777) begin
            n_fail++; $display("FAIL reset_release32: got %h expected 77777777", res32);
        end
    endtask

    task automatic test_basic_wrap();
        logic [7:0] va [6] = '{8'h12, 8'hFF, 8'h80, 8'hFF, 8'h0F, 8'h7F};
        logic [7:0] vb [6] = '{8'h34, 8'h01, 8'h80, 8'hFF, 8'h01, 8'h01};
        logic [7:0] ve [6] = '{8'h46, 8'h00, 8'h00, 8'hFE, 8'h10, 8'h80};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, va[i], vb[i], 16'hFFFF, 16'h0001, 32'hFFFF_FFFF, 32'h1);
            n_checks += 3;
            if (res8 !== ve[i]) begin
                n_fail++;
                $display("FAIL basic8 %h+%h: got %h expected %h", va[i], vb[i], res8, ve[i]);
            end
            if (res16 !== 16'h0000) begin
                n_fail++; $display("FAIL wrap16: got %h expected 0000", res16);
            end
            if (res32 !== 32'h0) begin
                n_fail++; $display("FAIL wrap32: got %h expected 0", res32);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [3] = '{8'd1, 8'd3, 8'd250};
        logic [7:0] vb [3] = '{8'd2, 8'd4, 8'd10};
        logic [7:0] ve [3] = '{8'd3, 8'd7, 8'd4};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, va[i], vb[i], 16'(va[i]), 16'(vb[i]), 32'(va[i]), 32'(vb[i]));
            n_checks += 2;
            if (res8 !== ve[i]) begin
                n_fail++; $display("FAIL pipe8[%0d]: got %0d expected %0d", i, res8, ve[i]);
            end
            if (res16 !== 16'(va[i]) + 16'(vb[i])) begin
                n_fail++; $display("FAIL pipe16[%0d]: got %0d expected %0d", i, res16,
                                   16'(va[i]) + 16'(vb[i]));
            end
        end
    endtask

    // Random pairs on all widths; rst_at selects a cycle with reset low (-1 for none).
    task automatic test_stream(input int n, input int rst_at);
        logic [31:0] x, y, u, v, p, q;
        logic        rst;
        for (int i = 0; i < n; i++) begin
            x = $urandom; y = $urandom; u = $urandom; v = $urandom;
            p = $urandom; q = $urandom;
            rst = (i == rst_at) ? 1'b0 : 1'b1;
            step(rst, 8'(x), 8'(y), 16'(u), 16'(v), p, q);
            n_checks += 3;
            if (res8 !== (rst ? 8'(ref_sum({24'd0, 8'(x)}, {24'd0, 8'(y)}, 8)) : 8'h00)) begin
                n_fail++;
                $display("FAIL rand8 cyc %0d rst=%b %h+%h: got %h", i, rst, 8'(x), 8'(y), res8);
            end
            if (res16 !== (rst ? 16'(ref_sum({16'd0, 16'(u)}, {16'd0, 16'(v)}, 16)) : 16'h0)) begin
                n_fail++;
                $display("FAIL rand16 cyc %0d rst=%b %h+%h: got %h", i, rst, 16'(u), 16'(v), res16);
            end
            if (res32 !== (rst ? ref_sum(p, q, 32) : 32'h0)) begin
                n_fail++;
                $display("FAIL rand32 cyc %0d rst=%b %h+%h: got %h", i, rst, p, q, res32);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_i  = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0; a32 = '0; b32 = '0;
        test_reset();
        test_basic_wrap();
        test_back_to_back();
        test_stream(12, 6);
        test_stream(20000, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_adder
